// File: rtl/param_serial_alu_pkg.sv
// Shared constants for the nibble-serial ALU: widths, op codes and FSM state encoding.
package param_SerialAluPkg;

    localparam int P_NBITS    = 4;
    localparam int C_NBEATS   = 8;
    localparam int C_BEATBITS = 3;
    localparam int C_OPBITS   = 3;

    // Operation encodings as seen on op_Xhl.
    localparam logic [C_OPBITS-1:0] OP_ADD = 3'd0;
    localparam logic [C_OPBITS-1:0] OP_SUB = 3'd1;
    localparam logic [C_OPBITS-1:0] OP_AND = 3'd2;
    localparam logic [C_OPBITS-1:0] OP_OR  = 3'd3;
    localparam logic [C_OPBITS-1:0] OP_XOR = 3'd4;
    localparam logic [C_OPBITS-1:0] OP_CMP = 3'd5;

    // FSM state encoding, kept as plain constants for compatibility with older blocks.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // SUB and CMP both run the adder with B inverted and carry-in seeded to 1.
    function automatic logic is_subtract(input logic [C_OPBITS-1:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/param_serial_alu_if.sv
// Control/operand/result bundle between the PC stage, the serial ALU and its consumers.
interface param_serial_alu_if
    import param_SerialAluPkg::*;
#(
    parameter int P_NBITS = 4
);
    logic                 start_Xhl;
    logic [C_OPBITS-1:0]  op_Xhl;
    logic                 flush_Xhl;
    logic [P_NBITS-1:0]   a_in_Xhl;
    logic [P_NBITS-1:0]   b_in_Xhl;
    logic                 busy_Xhl;
    logic                 last_beat_Xhl;
    logic [P_NBITS-1:0]   alu_mux_out_Xhl;
    logic                 alu_valid_Xhl;
    logic                 done_Xhl;
    logic                 cmp_eq_Xhl;
    logic                 cmp_lt_Xhl;
    logic                 cmp_ltu_Xhl;

    modport master (
        output start_Xhl, op_Xhl, flush_Xhl, a_in_Xhl, b_in_Xhl,
        input  busy_Xhl, last_beat_Xhl, alu_mux_out_Xhl, alu_valid_Xhl,
               done_Xhl, cmp_eq_Xhl, cmp_lt_Xhl, cmp_ltu_Xhl
    );

    modport slave (
        input  start_Xhl, op_Xhl, flush_Xhl, a_in_Xhl, b_in_Xhl,
        output busy_Xhl, last_beat_Xhl, alu_mux_out_Xhl, alu_valid_Xhl,
               done_Xhl, cmp_eq_Xhl, cmp_lt_Xhl, cmp_ltu_Xhl
    );
endinterface

// File: rtl/param_serial_alu_nibble_add_sub.sv
// Combinational nibble adder with optional B inversion; one beat of the serial add/subtract chain.
module param_NibbleAddSub
    import param_SerialAluPkg::*;
#(
    parameter int P_NBITS = 4
) (
    input  logic [P_NBITS-1:0] a,
    input  logic [P_NBITS-1:0] b,
    input  logic               invert_b,
    input  logic               carry_in,
    output logic [P_NBITS-1:0] sum,
    output logic               carry_out
);
    logic [P_NBITS-1:0] b_eff;
    logic [P_NBITS:0]   total;

    assign b_eff = invert_b ? ~b : b;
    assign total = {1'b0, a} + {1'b0, b_eff} + {{P_NBITS{1'b0}}, carry_in};
    assign {carry_out, sum} = total;
endmodule

// File: rtl/param_serial_alu.sv
// Nibble-serial ALU: FSM, beat counter, carry chain, registered result nibble and compare flags.
module param_serial_alu #(
    parameter int P_NBITS = 4,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    param_serial_alu_if.slave alu_if
);
    import param_SerialAluPkg::*;

    localparam int                   NBEATS    = XLEN / P_NBITS;
    localparam int                   BEAT_BITS = $clog2(NBEATS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NBEATS - 1);

    logic [1:0]           state_q;
    logic [C_OPBITS-1:0]  op_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic                 carry_q;
    logic                 eq_acc_q;
    logic [P_NBITS-1:0]   result_q;
    logic                 valid_q;
    logic                 eq_q;
    logic                 lt_q;
    logic                 ltu_q;

    logic                 accept;
    logic                 in_run;
    logic                 advance;
    logic                 final_beat;
    logic                 op_is_sub;
    logic                 op_is_arith;
    logic                 nibble_eq;
    logic [P_NBITS-1:0]   sum;
    logic                 carry_out;
    logic [P_NBITS-1:0]   result_nx;

    // Start is only honoured when not mid-operation; flush beats the last beat.
    assign accept      = alu_if.start_Xhl && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_run      = (state_q == ST_RUN);
    assign advance     = in_run && !alu_if.flush_Xhl;
    assign final_beat  = advance && (beat_q == LAST_BEAT);
    assign op_is_sub   = is_subtract(op_q);
    assign op_is_arith = (op_q == OP_ADD) || op_is_sub;
    assign nibble_eq   = (alu_if.a_in_Xhl == alu_if.b_in_Xhl);

    param_NibbleAddSub #(.P_NBITS(P_NBITS)) u_add_sub (
        .a         (alu_if.a_in_Xhl),
        .b         (alu_if.b_in_Xhl),
        .invert_b  (op_is_sub),
        .carry_in  (carry_q),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Select this beat's result nibble from the adder or the bitwise unit.
    always_comb begin
        // NOTE: default assignment first so every path drives result_nx and no latch is inferred.
        result_nx = sum;
        case (op_q)
            OP_AND:  result_nx = alu_if.a_in_Xhl & alu_if.b_in_Xhl;
            OP_OR:   result_nx = alu_if.a_in_Xhl | alu_if.b_in_Xhl;
            OP_XOR:  result_nx = alu_if.a_in_Xhl ^ alu_if.b_in_Xhl;
            default: result_nx = sum;
        endcase
    end

    // Control FSM: IDLE -> RUN -> DONE, with flush aborting RUN back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_RUN;
                ST_RUN: begin
                    if (alu_if.flush_Xhl)       state_q <= ST_IDLE;
                    else if (beat_q == LAST_BEAT) state_q <= ST_DONE;
                end
                ST_DONE: state_q <= accept ? ST_RUN : ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Op latch, beat counter, carry chain and equality accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_ADD;
            beat_q   <= '0;
            carry_q  <= 1'b0;
            eq_acc_q <= 1'b0;
        end else if (accept) begin
            op_q     <= alu_if.op_Xhl;
            beat_q   <= '0;
            carry_q  <= is_subtract(alu_if.op_Xhl);
            eq_acc_q <= 1'b1;
        end else if (advance) begin
            // Counter parks on the last beat; only a new start rewinds it.
            if (beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_BITS'(1);
            if (op_is_arith)         carry_q <= carry_out;
            eq_acc_q <= eq_acc_q & nibble_eq;
        end
    end

    // Registered result nibble and its valid, one cycle behind the consumed beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= advance;
            if (advance) result_q <= result_nx;
        end
    end

    // Compare flags update only on the final beat and otherwise hold across starts and flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
        end else if (final_beat) begin
            eq_q  <= eq_acc_q & nibble_eq;
            ltu_q <= op_is_sub & ~carry_out;
            lt_q  <= op_is_sub &
                     ((alu_if.a_in_Xhl[P_NBITS-1] != alu_if.b_in_Xhl[P_NBITS-1])
                      ? alu_if.a_in_Xhl[P_NBITS-1] : sum[P_NBITS-1]);
        end
    end

    assign alu_if.busy_Xhl        = in_run;
    assign alu_if.last_beat_Xhl   = in_run && (beat_q == LAST_BEAT);
    assign alu_if.done_Xhl        = (state_q == ST_DONE);
    assign alu_if.alu_mux_out_Xhl = result_q;
    assign alu_if.alu_valid_Xhl   = valid_q;
    assign alu_if.cmp_eq_Xhl      = eq_q;
    assign alu_if.cmp_lt_Xhl      = lt_q;
    assign alu_if.cmp_ltu_Xhl     = ltu_q;
endmodule

// File: tb/tb_param_serial_alu.sv
// Directed self-checking bench for the nibble-serial ALU.
module tb_param_serial_alu;
    import param_SerialAluPkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    param_serial_alu_if #(.P_NBITS(4)) alu_if ();

    param_serial_alu #(.P_NBITS(4), .XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .alu_if  (alu_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an op in the current cycle and returns in the DONE cycle (cycle 9).
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_eq,
                          input logic exp_lt, input logic exp_ltu, input logic poke_start);
        logic [31:0] got;
        got = '0;
        alu_if.start_Xhl = 1'b1;
        alu_if.op_Xhl    = op;
        step();
        alu_if.start_Xhl = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            alu_if.a_in_Xhl = a[4*(c-1) +: 4];
            alu_if.b_in_Xhl = b[4*(c-1) +: 4];
            alu_if.start_Xhl = poke_start && (c == 3);
            alu_if.op_Xhl    = (poke_start && (c == 3)) ? OP_AND : op;
            check({name, " busy"}, 32'(alu_if.busy_Xhl), 32'd1);
            check({name, " last_beat"}, 32'(alu_if.last_beat_Xhl), 32'(c == 8));
            check({name, " done_in_run"}, 32'(alu_if.done_Xhl), 32'd0);
            if (c == 1) begin
                check({name, " valid_c1"}, 32'(alu_if.alu_valid_Xhl), 32'd0);
            end else begin
                check({name, " valid"}, 32'(alu_if.alu_valid_Xhl), 32'd1);
                got[4*(c-2) +: 4] = alu_if.alu_mux_out_Xhl;
            end
            step();
        end
        alu_if.start_Xhl = 1'b0;
        got[31:28] = alu_if.alu_mux_out_Xhl;
        check({name, " valid_c9"}, 32'(alu_if.alu_valid_Xhl), 32'd1);
        check({name, " busy_c9"}, 32'(alu_if.busy_Xhl), 32'd0);
        check({name, " done"}, 32'(alu_if.done_Xhl), 32'd1);
        check({name, " result"}, got, exp_res);
        check({name, " eq"}, 32'(alu_if.cmp_eq_Xhl), 32'(exp_eq));
        check({name, " lt"}, 32'(alu_if.cmp_lt_Xhl), 32'(exp_lt));
        check({name, " ltu"}, 32'(alu_if.cmp_ltu_Xhl), 32'(exp_ltu));
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"}, 32'(alu_if.busy_Xhl), 32'd0);
        check({name, " last_beat"}, 32'(alu_if.last_beat_Xhl), 32'd0);
        check({name, " mux_out"}, 32'(alu_if.alu_mux_out_Xhl), 32'd0);
        check({name, " valid"}, 32'(alu_if.alu_valid_Xhl), 32'd0);
        check({name, " done"}, 32'(alu_if.done_Xhl), 32'd0);
        check({name, " eq"}, 32'(alu_if.cmp_eq_Xhl), 32'd0);
        check({name, " lt"}, 32'(alu_if.cmp_lt_Xhl), 32'd0);
        check({name, " ltu"}, 32'(alu_if.cmp_ltu_Xhl), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        total = 0;
        bad   = 0;
        reset_n          = 1'b0;
        alu_if.start_Xhl = 1'b0;
        alu_if.op_Xhl    = OP_ADD;
        alu_if.flush_Xhl = 1'b0;
        alu_if.a_in_Xhl  = '0;
        alu_if.b_in_Xhl  = '0;

        // Reset state.
        step();
        check_all_zero("reset");
        #2 reset_n = 1'b1;
        step();

        // ADD with a single nonzero nibble in A.
        run_op("add1", OP_ADD, 32'h0008_0000, 32'h0000_0004, 32'h0008_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // ADD with carry rippling across seven nibbles.
        run_op("add_carry", OP_ADD, 32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // SUB with negative result.
        run_op("sub", OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("idle_after_done", 32'(alu_if.done_Xhl), 32'd0);

        // Flush during beat 3: back to IDLE, no done, flags from SUB kept.
        alu_if.start_Xhl = 1'b1;
        alu_if.op_Xhl    = OP_CMP;
        step();
        alu_if.start_Xhl = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            alu_if.a_in_Xhl  = 4'h0;
            alu_if.b_in_Xhl  = 4'h0;
            alu_if.flush_Xhl = (c == 4);
            step();
        end
        alu_if.flush_Xhl = 1'b0;
        check("flush busy", 32'(alu_if.busy_Xhl), 32'd0);
        check("flush valid", 32'(alu_if.alu_valid_Xhl), 32'd0);
        check("flush done", 32'(alu_if.done_Xhl), 32'd0);
        check("flush eq", 32'(alu_if.cmp_eq_Xhl), 32'd0);
        check("flush lt", 32'(alu_if.cmp_lt_Xhl), 32'd1);
        check("flush ltu", 32'(alu_if.cmp_ltu_Xhl), 32'd1);
        step();
        check("flush done_next", 32'(alu_if.done_Xhl), 32'd0);

        // Signed CMP with differing sign bits; a start pulse mid-RUN must be ignored.
        run_op("cmp_sign", OP_CMP, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        step();

        // Back-to-back: XOR launched in the ADD's DONE cycle.
        run_op("add_eq", OP_ADD, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("xor_b2b", OP_XOR, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // CMP of equal operands.
        run_op("cmp_eq", OP_CMP, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Asynchronous reset in beat 5 of an ADD.
        ra = 32'h1111_1111;
        alu_if.start_Xhl = 1'b1;
        alu_if.op_Xhl    = OP_ADD;
        step();
        alu_if.start_Xhl = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            alu_if.a_in_Xhl = ra[4*(c-1) +: 4];
            alu_if.b_in_Xhl = ra[4*(c-1) +: 4];
            if (c < 6) step();
        end
        check("midrst pre mux_out", 32'(alu_if.alu_mux_out_Xhl), 32'd2);
        check("midrst pre eq_flag", 32'(alu_if.cmp_eq_Xhl), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        reset_n = 1'b1;
        step();

        // Fresh ADD after reset release.
        run_op("add_post_rst", OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
